pc_register: RTL and testbench

//  Fetch-stage program counter register, the consumer of pc_adder's incremented PC.

---
 rtl/pc_register_if.sv | 51 +++++
 rtl/pc_register.sv | 150 +++++++++++++++
 tb/tb_pc_register.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_register_if.sv
// -----------------------------------------------------------------------------
// pc_register_if
//   Bundles the control and address signals of the fetch-stage PC register.
//   The slave modport is used by pc_register. The master modport is used by
//   whatever drives it (debug unit, hazard unit, ID stage, or a testbench).
//
//   Signals (directions as seen by the slave):
//     i_enable            in   debug unit: continuous run
//     i_step              in   debug unit: single-advance pulse
//     i_stall             in   hazard unit: hold PC this cycle
//     i_next_pc           in   sequential PC from pc_adder
//     i_branch            in   taken branch resolved in ID
//     i_branch_target     in   branch target address
//     i_jump              in   jump resolved in ID
//     i_jump_target       in   jump target address
//     i_halt              in   HALT instruction decoded
//     o_pc                out  current fetch address
//     o_halted            out  HALTED state flag
//     o_redirect_pending  out  redirect stored, not yet applied
//     o_adv_count         out  number of PC advances since reset
// -----------------------------------------------------------------------------
interface pc_register_if #(
  parameter int PC_SZ  = 32,
  parameter int CNT_SZ = 32
);
  logic              i_enable;
  logic              i_step;
  logic              i_stall;
  logic [PC_SZ-1:0]  i_next_pc;
  logic              i_branch;
  logic [PC_SZ-1:0]  i_branch_target;
  logic              i_jump;
  logic [PC_SZ-1:0]  i_jump_target;
  logic              i_halt;
  logic [PC_SZ-1:0]  o_pc;
  logic              o_halted;
  logic              o_redirect_pending;
  logic [CNT_SZ-1:0] o_adv_count;

  modport slave (
    input  i_enable, i_step, i_stall, i_next_pc,
    input  i_branch, i_branch_target, i_jump, i_jump_target, i_halt,
    output o_pc, o_halted, o_redirect_pending, o_adv_count
  );

  modport master (
    output i_enable, i_step, i_stall, i_next_pc,
    output i_branch, i_branch_target, i_jump, i_jump_target, i_halt,
    input  o_pc, o_halted, o_redirect_pending, o_adv_count
  );
endinterface : pc_register_if

// File: rtl/pc_register.sv
// -----------------------------------------------------------------------------
// pc_register
//   Fetch-stage program counter. Every cycle it picks the next fetch address
//   from the sequential PC, a jump target, a branch target, or a previously
//   stored redirect, and registers it. It absorbs hazard stalls, keeps
//   redirects that arrive while the PC cannot move, stops for good on HALT,
//   and obeys debug-unit run/step control.
//
//   Ports:
//     i_clk    in   clock, rising edge
//     i_rst_n  in   asynchronous reset, active-low
//     bus      slave modport of pc_register_if (control inputs, targets,
//              o_pc / o_halted / o_redirect_pending / o_adv_count)
//
//   Parameters:
//     PC_SZ     PC width in bits
//     RESET_PC  PC value loaded on reset
//     CNT_SZ    width of the advance counter (wraps modulo 2^CNT_SZ)
// -----------------------------------------------------------------------------
module pc_register #(
  parameter int               PC_SZ    = 32,
  parameter logic [PC_SZ-1:0] RESET_PC = '0,
  parameter int               CNT_SZ   = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  pc_register_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PC_SZ-1:0]  pc_q, pc_d;
  logic [PC_SZ-1:0]  pend_target_q, pend_target_d;
  logic              pend_valid_q, pend_valid_d;
  logic              halted_q, halted_d;
  logic [CNT_SZ-1:0] cnt_q, cnt_d;

  logic              in_idle;
  logic              in_run;
  logic              adv;
  logic              redirect;
  logic              store;
  logic [PC_SZ-1:0]  redirect_target;
  logic [PC_SZ-1:0]  sel_pc;

  assign in_idle = (state_q == ST_IDLE);
  assign in_run  = (state_q == ST_RUN);

  // The PC moves when running freely, or on a debug step from IDLE. A HALT
  // seen in RUN freezes the PC on the very cycle it is decoded.
  assign adv = (in_run  & ~bus.i_stall & ~bus.i_halt)
             | (in_idle &  bus.i_step  & ~bus.i_stall);

  // Jump outranks branch both when applied directly and when stored.
  assign redirect        = bus.i_jump | bus.i_branch;
  assign redirect_target = bus.i_jump ? bus.i_jump_target : bus.i_branch_target;

  // A redirect that cannot be applied now is remembered: either the hazard
  // unit is stalling us, or we sit in IDLE waiting for a step. HALTED never
  // stores anything.
  assign store = redirect
               & (((in_run | in_idle) & bus.i_stall) | (in_idle & ~bus.i_step));

  // A fresh redirect always beats the stored one.
  assign sel_pc = redirect     ? redirect_target :
                  pend_valid_q ? pend_target_q   :
                                 bus.i_next_pc;

  // ---------------------------------------------------------------------------
  // Control FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven from always_comb gets a default on the first
  // lines, so no path through the block can leave it unassigned and infer a
  // latch.
  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // A step coinciding with enable advances once and then keeps running.
        if (bus.i_enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        // HALT is an instruction in flight; it wins over losing enable.
        if (bus.i_halt)         state_d = ST_HALTED;
        else if (!bus.i_enable) state_d = ST_IDLE;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: next PC, stored redirect, advance counter
  // ---------------------------------------------------------------------------
  always_comb begin : datapath_next
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    pend_valid_d  = pend_valid_q;
    cnt_d         = cnt_q;
    halted_d      = (state_d == ST_HALTED);

    if (adv) begin
      // Instruction fetches are word aligned whatever the source.
      pc_d         = {sel_pc[PC_SZ-1:2], 2'b00};
      // Either the stored target was consumed or a newer redirect made it
      // stale; both ways nothing is left pending.
      pend_valid_d = 1'b0;
      cnt_d        = cnt_q + CNT_SZ'(1);
    end else if (store) begin
      pend_target_d = redirect_target;
      pend_valid_d  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of block order.
  // NOTE: all registers here are control/state flops, not a memory array, so
  // each one is cleared by the asynchronous reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      pend_target_q <= '0;
      pend_valid_q  <= 1'b0;
      halted_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      pend_valid_q  <= pend_valid_d;
      halted_q      <= halted_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.o_pc               = pc_q;
  assign bus.o_halted           = halted_q;
  assign bus.o_redirect_pending = pend_valid_q;
  assign bus.o_adv_count        = cnt_q;

endmodule : pc_register

// File: tb/tb_pc_register.sv
// -----------------------------------------------------------------------------
// tb_pc_register
//   Directed bench for pc_register. Each stimulus step pushes the expected
//   post-edge outputs into a queue; a separate monitor samples the DUT 1 ns
//   after every rising clock edge (and after an asynchronous reset assertion)
//   and compares against the head of the queue. The counter is built 4 bits
//   wide so the modulo wrap is reached within the directed sequence.
// -----------------------------------------------------------------------------
module tb_pc_register;

  localparam int PC_SZ  = 32;
  localparam int CNT_SZ = 4;

  typedef struct packed {
    logic [PC_SZ-1:0]  pc;
    logic              halted;
    logic              pend;
    logic [CNT_SZ-1:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  exp_t  exp_q[$];
  string name_q[$];

  pc_register_if #(.PC_SZ(PC_SZ), .CNT_SZ(CNT_SZ)) bus ();

  pc_register #(
    .PC_SZ   (PC_SZ),
    .RESET_PC(32'h0),
    .CNT_SZ  (CNT_SZ)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // pc_adder stand-in: sequential PC follows the current fetch address.
  assign bus.i_next_pc = bus.o_pc + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic push_exp(input string name, input logic [PC_SZ-1:0] e_pc,
                          input logic e_h, input logic e_p,
                          input logic [CNT_SZ-1:0] e_cnt);
    exp_t e;
    e.pc = e_pc; e.halted = e_h; e.pend = e_p; e.cnt = e_cnt;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic set_in(input logic en, input logic stp, input logic stl,
                        input logic br, input logic [PC_SZ-1:0] bt,
                        input logic jp, input logic [PC_SZ-1:0] jt,
                        input logic hlt);
    bus.i_enable        = en;
    bus.i_step          = stp;
    bus.i_stall         = stl;
    bus.i_branch        = br;
    bus.i_branch_target = bt;
    bus.i_jump          = jp;
    bus.i_jump_target   = jt;
    bus.i_halt          = hlt;
  endtask

  // One clock of stimulus: drive on the falling edge, expect after the next
  // rising edge.
  task automatic tick(input string name,
                      input logic en, input logic stp, input logic stl,
                      input logic br, input logic [PC_SZ-1:0] bt,
                      input logic jp, input logic [PC_SZ-1:0] jt,
                      input logic hlt,
                      input logic [PC_SZ-1:0] e_pc, input logic e_h,
                      input logic e_p, input logic [CNT_SZ-1:0] e_cnt);
    @(negedge clk);
    set_in(en, stp, stl, br, bt, jp, jt, hlt);
    push_exp(name, e_pc, e_h, e_p, e_cnt);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin : monitor
    exp_t  e;
    string n;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (bus.o_pc !== e.pc || bus.o_halted !== e.halted ||
            bus.o_redirect_pending !== e.pend || bus.o_adv_count !== e.cnt) begin
          errors++;
          $display("FAIL %s: got pc=%h halted=%b pend=%b cnt=%0d, expected pc=%h halted=%b pend=%b cnt=%0d",
                   n, bus.o_pc, bus.o_halted, bus.o_redirect_pending, bus.o_adv_count,
                   e.pc, e.halted, e.pend, e.cnt);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations outstanding", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  //   tick(name, en, step, stall, br, br_tgt, jp, jp_tgt, halt,
  //        exp_pc, exp_halted, exp_pending, exp_count)
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #2;
    push_exp("reset", 32'h0, 1'b0, 1'b0, 4'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Run from reset; the first enabled edge only moves IDLE -> RUN.
    tick("t1_enter_run", 1,0,0, 0,32'h0, 0,32'h0, 0,  32'h000, 0,0, 4'd0);
    tick("t1_run_4",     1,0,0, 0,32'h0, 0,32'h0, 0,  32'h004, 0,0, 4'd1);
    tick("t1_run_8",     1,0,0, 0,32'h0, 0,32'h0, 0,  32'h008, 0,0, 4'd2);
    // Stall holds PC and count.
    tick("t2_stall_1",   1,0,1, 0,32'h0, 0,32'h0, 0,  32'h008, 0,0, 4'd2);
    tick("t2_stall_2",   1,0,1, 0,32'h0, 0,32'h0, 0,  32'h008, 0,0, 4'd2);
    tick("t2_release",   1,0,0, 0,32'h0, 0,32'h0, 0,  32'h00C, 0,0, 4'd3);
    tick("t3_run_10",    1,0,0, 0,32'h0, 0,32'h0, 0,  32'h010, 0,0, 4'd4);
    // Branch while stalled is stored, then applied when the stall drops.
    tick("t3_br_stalled",1,0,1, 1,32'h40, 0,32'h0, 0, 32'h010, 0,1, 4'd4);
    tick("t3_br_apply",  1,0,0, 0,32'h0, 0,32'h0, 0,  32'h040, 0,0, 4'd5);
    // Newest stored redirect wins; jump beats branch when storing; alignment.
    tick("t3_store_br",  1,0,1, 1,32'h100, 0,32'h0, 0,   32'h040, 0,1, 4'd5);
    tick("t3_store_jp",  1,0,1, 1,32'h100, 1,32'h206, 0, 32'h040, 0,1, 4'd5);
    tick("t3_apply_jp",  1,0,0, 0,32'h0, 0,32'h0, 0,     32'h204, 0,0, 4'd6);
    // Jump over branch, unaligned target.
    tick("t4_jump_prio", 1,0,0, 1,32'h40, 1,32'h83, 0,   32'h080, 0,0, 4'd7);
    // Fresh jump beats a stored branch and clears the pending flag.
    tick("t4_store_br",  1,0,1, 1,32'h500, 0,32'h0, 0,   32'h080, 0,1, 4'd7);
    tick("t4_newer_wins",1,0,0, 0,32'h0, 1,32'h600, 0,   32'h600, 0,0, 4'd8);
    tick("t4_sequential",1,0,0, 0,32'h0, 0,32'h0, 0,     32'h604, 0,0, 4'd9);
    // Dropping enable in RUN still advances on that edge, then IDLE.
    tick("t6_leave_run", 0,0,0, 0,32'h0, 0,32'h0, 0,  32'h608, 0,0, 4'd10);
    tick("t6_idle",      0,0,0, 0,32'h0, 0,32'h0, 0,  32'h608, 0,0, 4'd10);
    tick("t6_step_1",    0,1,0, 0,32'h0, 0,32'h0, 0,  32'h60C, 0,0, 4'd11);
    tick("t6_gap_1",     0,0,0, 0,32'h0, 0,32'h0, 0,  32'h60C, 0,0, 4'd11);
    tick("t6_step_2",    0,1,0, 0,32'h0, 0,32'h0, 0,  32'h610, 0,0, 4'd12);
    tick("t6_gap_2",     0,0,0, 0,32'h0, 0,32'h0, 0,  32'h610, 0,0, 4'd12);
    tick("t6_step_3",    0,1,0, 0,32'h0, 0,32'h0, 0,  32'h614, 0,0, 4'd13);
    tick("t6_step_stall",0,1,1, 0,32'h0, 0,32'h0, 0,  32'h614, 0,0, 4'd13);
    // Redirect in IDLE without a step is stored; the next step uses it.
    tick("t6_idle_redir",0,0,0, 1,32'h700, 0,32'h0, 0, 32'h614, 0,1, 4'd13);
    tick("t6_step_pend", 0,1,0, 0,32'h0, 0,32'h0, 0,   32'h700, 0,0, 4'd14);
    // Step and enable together: advance and enter RUN.
    tick("t6_step_en",   1,1,0, 0,32'h0, 0,32'h0, 0,  32'h704, 0,0, 4'd15);
    // Count wraps 15 -> 0.
    tick("t6_cnt_wrap",  1,0,0, 0,32'h0, 0,32'h0, 0,  32'h708, 0,0, 4'd0);
    // HALT: stored redirect kept but never applied, everything else ignored.
    tick("t5_jump_20",   1,0,0, 0,32'h0, 1,32'h20, 0,  32'h020, 0,0, 4'd1);
    tick("t5_store_br",  1,0,1, 1,32'h900, 0,32'h0, 0, 32'h020, 0,1, 4'd1);
    tick("t5_halt",      1,0,0, 0,32'h0, 0,32'h0, 1,   32'h020, 1,1, 4'd1);
    for (int i = 0; i < 10; i++) begin
      tick("t5_halted_hold", 1,1,0, logic'(i[0]),32'h300, 1,32'h44, logic'(i[1]),
           32'h020, 1,1, 4'd1);
    end

    // Asynchronous reset takes effect before the next edge.
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    push_exp("t5_async_reset", 32'h0, 1'b0, 1'b0, 4'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Back in IDLE with nothing pending.
    tick("t7_idle",      0,0,0, 0,32'h0, 0,32'h0, 0,  32'h000, 0,0, 4'd0);
    tick("t7_enter_run", 1,0,0, 0,32'h0, 0,32'h0, 0,  32'h000, 0,0, 4'd0);
    tick("t7_run_4",     1,0,0, 0,32'h0, 0,32'h0, 0,  32'h004, 0,0, 4'd1);

    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never compared, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pc_register
